mult24_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one sequential 24×24 multiplier (start/done handshake, 48-bit product) between `N_REQ` requesters. Picks one pending request, latches its operands, pulses the multiplier start, waits for done (with timeout), and returns the product with a one-cycle done strobe to the winner. It sits between the requesting datapath blocks and the single multiplier instance.

---
 rtl/mult24_arbiter_pkg.sv | 24 ++
 rtl/mult24_arbiter_rr_pick.sv | 35 +++
 rtl/mult24_arbiter.sv | 120 ++++++++++++
 tb/tb_mult24_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mult24_arbiter_pkg.sv
// Shared definitions for the mult24 arbiter slice.
//   arb_state_t    : sequencer states (IDLE, LAUNCH, WAIT, RESP)
//   DEF_N_REQ      : default requester count
//   DEF_W          : default operand width (product is 2*W)
//   DEF_TIMEOUT    : default WAIT cycle limit before abort
//   idx_width()    : index width for a given requester count
package mult24_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  localparam int unsigned DEF_N_REQ   = 4;
  localparam int unsigned DEF_W       = 24;
  localparam int unsigned DEF_TIMEOUT = 255;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult24_arbiter_rr_pick.sv
// Combinational cyclic priority picker.
//   req   : request vector
//   ptr   : highest-priority position this round
//   valid : at least one request present
//   idx   : first set bit at or after ptr, wrapping to bit 0
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Two passes instead of a modulo: the upper segment [ptr..N-1] is scanned
  // first; only if it is empty does the lower segment [0..ptr-1] win.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!valid && req[i] && (i >= 32'(ptr))) begin
        valid = 1'b1;
        idx   = IW'(i);
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!valid && req[i]) begin
        valid = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/mult24_arbiter.sv
// Round-robin arbiter/sequencer sharing one sequential W x W multiplier.
//   clk, rst             : clock; asynchronous active-low reset
//   req                  : level request per requester, held until its done
//   req_a, req_b         : packed operands, requester i at [i*W +: W]
//   grant                : one-hot owner from LAUNCH through RESP
//   done                 : one-cycle strobe to owner, result/err valid
//   result, err          : product (or 0 on timeout) and timeout flag
//   busy                 : high outside IDLE
//   mul_start            : one-cycle multiplier start pulse
//   mul_a, mul_b         : operands latched at arbitration
//   mul_result, mul_done : multiplier product and completion (WAIT only)
module mult24_arbiter
  import mult24_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = DEF_N_REQ,
  parameter int unsigned W       = DEF_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   done,
  output logic [2*W-1:0]     result,
  output logic               err,
  output logic               busy,
  output logic               mul_start,
  output logic [W-1:0]       mul_a,
  output logic [W-1:0]       mul_b,
  input  logic [2*W-1:0]     mul_result,
  input  logic               mul_done
);

  localparam int unsigned IW = idx_width(N_REQ);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  arb_state_t        state;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     idx;
  logic [CW-1:0]     cnt;
  logic              pick_valid;
  logic [IW-1:0]     pick_idx;
  logic [N_REQ-1:0]  owner_oh;
  logic [W-1:0]      a_arr [N_REQ];
  logic [W-1:0]      b_arr [N_REQ];

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      a_arr[i] = req_a[i*W +: W];
      b_arr[i] = req_b[i*W +: W];
    end
  end

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      ptr    <= '0;
      idx    <= '0;
      cnt    <= '0;
      result <= '0;
      err    <= 1'b0;
      mul_a  <= '0;
      mul_b  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            idx   <= pick_idx;
            mul_a <= a_arr[pick_idx];
            mul_b <= b_arr[pick_idx];
            state <= LAUNCH;
          end
        end
        LAUNCH: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // Completion is checked before the limit so a same-cycle
          // mul_done beats the abort.
          if (mul_done) begin
            result <= mul_result;
            err    <= 1'b0;
            state  <= RESP;
          end else if (cnt == CW'(TIMEOUT)) begin
            result <= '0;
            err    <= 1'b1;
            state  <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          ptr   <= (idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign owner_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  assign busy      = (state != IDLE);
  assign mul_start = (state == LAUNCH);
  assign grant     = busy ? owner_oh : '0;
  assign done      = (state == RESP) ? owner_oh : '0;

endmodule

// File: tb/tb_mult24_arbiter.sv
module tb_mult24_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned W   = 24;
  localparam int unsigned LAT = 30;

  logic           clk = 1'b0;
  logic           rst;

  // main instance (TIMEOUT 40) with a behavioural multiplier
  logic [N-1:0]   req;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   grant, done;
  logic [2*W-1:0] result, mul_result;
  logic           err, busy, mul_start, mul_done;
  logic [W-1:0]   mul_a, mul_b;
  logic           mdone, inj;
  int             mcnt;

  // second instance (TIMEOUT 8) with a directly driven multiplier
  logic [N-1:0]   req_t;
  logic [N*W-1:0] req_a_t, req_b_t;
  logic [N-1:0]   grant_t, done_t;
  logic [2*W-1:0] result_t, mul_result_t;
  logic           err_t, busy_t, mul_start_t, mul_done_t;
  logic [W-1:0]   mul_a_t, mul_b_t;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  mult24_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(40)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .grant(grant), .done(done), .result(result), .err(err), .busy(busy),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_result(mul_result), .mul_done(mul_done)
  );

  mult24_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(8)) dut_to (
    .clk(clk), .rst(rst), .req(req_t), .req_a(req_a_t), .req_b(req_b_t),
    .grant(grant_t), .done(done_t), .result(result_t), .err(err_t), .busy(busy_t),
    .mul_start(mul_start_t), .mul_a(mul_a_t), .mul_b(mul_b_t),
    .mul_result(mul_result_t), .mul_done(mul_done_t)
  );

  // Multiplier model: done pulses LAT+1 cycles after the start pulse.
  assign mul_result = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
  assign mul_done   = mdone | inj;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcnt  <= 0;
      mdone <= 1'b0;
    end else begin
      mdone <= 1'b0;
      if (mul_start) mcnt <= LAT;
      else if (mcnt > 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1) mdone <= 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done();
    while (done == '0 && cyc < 300) tick();
  endtask

  task automatic wait_start();
    while (!mul_start && cyc < 300) tick();
  endtask

  initial begin
    rst = 1'b0; req = '0; req_a = '0; req_b = '0; inj = 1'b0;
    req_t = '0; req_a_t = '0; req_b_t = '0; mul_done_t = 1'b0;
    mul_result_t = 48'h123456789ABC;
    tick(); tick();
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", mul_start, 0);
    chk("rst_mul_ab", {mul_a, mul_b}, 0);
    rst = 1'b1;
    tick();

    // single request, 17 * 139
    req_a[0*W +: W] = 24'd17; req_b[0*W +: W] = 24'd139;
    req = 4'b0001; cyc = 0;
    tick();
    chk("t1_start", mul_start, 1);
    chk("t1_grant", grant, 4'b0001);
    chk("t1_ops", {mul_a, mul_b}, {24'd17, 24'd139});
    tick();
    chk("t1_start_pulse", mul_start, 0);
    chk("t1_busy", busy, 1);
    wait_done();
    chk("t1_done", done, 4'b0001);
    chk("t1_done_cycle", cyc, 33);
    chk("t1_result", result, 2363);
    chk("t1_err", err, 0);
    req = '0;
    tick();
    chk("t1_idle", {busy, done, grant}, 0);

    // req1 and req2 together, ptr=1
    req_a[1*W +: W] = 24'd124; req_b[1*W +: W] = 24'd530;
    req_a[2*W +: W] = 24'd3;   req_b[2*W +: W] = 24'd5;
    req = 4'b0110; cyc = 0;
    wait_done();
    chk("t2_done1", done, 4'b0010);
    chk("t2_result1", result, 65720);
    req[1] = 1'b0;
    tick(); cyc = 0;
    wait_start();
    chk("t2_grant2", grant, 4'b0100);
    wait_done();
    chk("t2_done2", done, 4'b0100);
    chk("t2_result2", result, 15);
    req[2] = 1'b0;
    tick();

    // all four held; ptr=3 so order 3,0,1,2,3
    for (int i = 0; i < 4; i++) begin
      req_a[i*W +: W] = 24'(i + 1);
      req_b[i*W +: W] = 24'd100;
    end
    req = 4'b1111;
    begin
      logic [3:0] exp_g [5];
      int         exp_r [5];
      exp_g[0] = 4'b1000; exp_g[1] = 4'b0001; exp_g[2] = 4'b0010;
      exp_g[3] = 4'b0100; exp_g[4] = 4'b1000;
      exp_r[0] = 400; exp_r[1] = 100; exp_r[2] = 200; exp_r[3] = 300; exp_r[4] = 400;
      for (int k = 0; k < 5; k++) begin
        cyc = 0;
        wait_start();
        chk($sformatf("t3_grant%0d", k), grant, exp_g[k]);
        wait_done();
        chk($sformatf("t3_done%0d", k), done, exp_g[k]);
        chk($sformatf("t3_result%0d", k), result, exp_r[k]);
        if (k == 4) req = '0;
        tick();
      end
    end

    // mul_done outside WAIT is ignored; ptr=0
    inj = 1'b1;
    tick();
    chk("t4_idle_inj", {busy, done}, 0);
    req_a[0*W +: W] = 24'd2; req_b[0*W +: W] = 24'd3;
    req = 4'b0001; cyc = 0;
    tick();
    chk("t4_launch", grant, 4'b0001);
    tick();
    inj = 1'b0;
    chk("t4_wait_busy", busy, 1);
    tick();
    chk("t4_no_early_done", done, 0);
    wait_done();
    chk("t4_result", result, 6);
    chk("t4_done_cycle", cyc, 33);
    req = '0;
    tick();

    // reset during WAIT; ptr=1 so req3 wins before reset, req0 after
    req_a[0*W +: W] = 24'd6; req_b[0*W +: W] = 24'd7;
    req_a[3*W +: W] = 24'd5; req_b[3*W +: W] = 24'd7;
    req = 4'b1001; cyc = 0;
    tick();
    chk("t5_grant_pre", grant, 4'b1000);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("t5_async_outs", {grant, done, busy, mul_start, err}, 0);
    chk("t5_async_regs", {result, mul_a, mul_b}, 0);
    tick(); tick(); tick();
    chk("t5_hold_done", done, 0);
    rst = 1'b1; cyc = 0;
    tick();
    chk("t5_grant_post", grant, 4'b0001);
    chk("t5_ops_post", {mul_a, mul_b}, {24'd6, 24'd7});
    wait_done();
    chk("t5_result0", result, 42);
    req[0] = 1'b0;
    tick(); cyc = 0;
    wait_start();
    chk("t5_grant3", grant, 4'b1000);
    wait_done();
    chk("t5_result3", result, 35);
    req = '0;
    tick();

    // max operands, then operands changed and req dropped during WAIT
    req_a[0*W +: W] = 24'hFFFFFF; req_b[0*W +: W] = 24'hFFFFFF;
    req = 4'b0001; cyc = 0;
    tick();
    chk("t6_ops", {mul_a, mul_b}, {24'hFFFFFF, 24'hFFFFFF});
    tick(); tick();
    req_a[0*W +: W] = 24'd1; req_b[0*W +: W] = 24'd2; req = '0;
    tick();
    chk("t6_ops_held", {mul_a, mul_b}, {24'hFFFFFF, 24'hFFFFFF});
    wait_done();
    chk("t6_done", done, 4'b0001);
    chk("t6_result", result, 48'hFFFFFE000001);
    tick();
    chk("t6_idle", busy, 0);

    // timeout instance: never completes
    req_a_t[2*W +: W] = 24'd9; req_b_t[2*W +: W] = 24'd9;
    req_t = 4'b0100; cyc = 0;
    while (done_t == '0 && cyc < 100) tick();
    chk("t7_done", done_t, 4'b0100);
    chk("t7_cycle", cyc, 11);
    chk("t7_err", err_t, 1);
    chk("t7_result", result_t, 0);
    req_t = '0;
    tick();
    chk("t7_idle", {busy_t, done_t}, 0);

    // completion on the same cycle the counter reaches TIMEOUT
    req_t = 4'b0100; cyc = 0;
    while (cyc < 10) tick();
    chk("t8_no_done_yet", done_t, 0);
    mul_done_t = 1'b1;
    tick();
    mul_done_t = 1'b0;
    chk("t8_done", done_t, 4'b0100);
    chk("t8_err", err_t, 0);
    chk("t8_result", result_t, 48'h123456789ABC);
    req_t = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
